// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: shifts a captured 55-bit ALU result packet out MSB-first
// on one serial line. Normal packets send all five 11-bit words; error packets
// (CTL data bit 7 set) send only the CTL word. The line idles high, and
// optional idle-high gaps can be inserted between the words of a packet.
module mtm_alu_serializer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic        clk,
  input  logic        rst_n,      // active-high synchronous reset (name kept from the core)
  input  logic [54:0] ALU_out,
  input  logic        data_ready,
  output logic        sout,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] CLK_ONE  = CLK_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [54:0]      r_shift;
  logic [3:0]       r_bit_cnt;
  logic [2:0]       r_word_cnt;
  logic [CLK_W-1:0] r_clk_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;

  logic             w_is_error;
  logic [54:0]      w_load;
  logic [54:0]      w_shifted;
  logic             w_bit_end;

  // CTL word is {start, type, data[7:0], stop}; its data bit 7 sits at ALU_out[8].
  assign w_is_error = ALU_out[8];
  // An error packet keeps only the CTL word, left-aligned so it goes out first.
  assign w_load     = w_is_error ? {ALU_out[10:0], {44{1'b1}}} : ALU_out;
  assign w_shifted  = {r_shift[53:0], 1'b1};
  assign w_bit_end  = (r_clk_cnt == CLK_LAST);

  // Main FSM: capture, shift, gap; all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_clk_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_sout     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A packet offered while a transfer is in flight is dropped and flagged.
      if (data_ready && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_sout <= 1'b1;
          if (data_ready) begin
            r_shift    <= w_load;
            r_word_cnt <= w_is_error ? 3'd4 : 3'd0;
            r_bit_cnt  <= '0;
            r_clk_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_sout     <= w_load[54];
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_shift   <= w_shifted;
            if (r_bit_cnt == 4'd10) begin
              r_bit_cnt <= '0;
              if (r_word_cnt == 3'd4) begin
                r_word_cnt <= '0;
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_sout     <= 1'b1;
              end else if (GAP_BITS > 0) begin
                r_word_cnt <= r_word_cnt + 3'd1;
                r_state    <= S_GAP;
                r_sout     <= 1'b1;
              end else begin
                r_word_cnt <= r_word_cnt + 3'd1;
                r_sout     <= r_shift[53];
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_sout    <= r_shift[53];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_ONE;
          end
        end
        S_GAP: begin
          // The shift register already holds the next word's MSB at bit 54.
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_clk_cnt <= '0;
            r_state   <= S_SHIFT;
            r_sout    <= r_shift[54];
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_sout  <= 1'b1;
        end
      endcase
    end
  end

  assign sout    = r_sout;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: two instances (CPB=1/GAP=0 and CPB=4/GAP=2)
// are driven with directed and random packets and compared cycle by cycle
// against a waveform built from the packet format.
module tb_mtm_alu_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, dr_a, sout_a, busy_a, done_a, ovr_a;
  logic        rst_b, dr_b, sout_b, busy_b, done_b, ovr_b;
  logic [54:0] alu_a, alu_b;

  mtm_alu_serializer #(.CLKS_PER_BIT(1), .GAP_BITS(0)) u_fast (
    .clk(clk), .rst_n(rst_a), .ALU_out(alu_a), .data_ready(dr_a),
    .sout(sout_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  mtm_alu_serializer #(.CLKS_PER_BIT(4), .GAP_BITS(2)) u_slow (
    .clk(clk), .rst_n(rst_b), .ALU_out(alu_b), .data_ready(dr_b),
    .sout(sout_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];

  function automatic int cpb_of(input int which);
    return (which != 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int which);
    return (which != 0) ? 2 : 0;
  endfunction

  function automatic logic [54:0] rnd55();
    logic [54:0] r;
    r = {23'($urandom), 32'($urandom)};
    return r;
  endfunction

  function automatic logic [54:0] make_pkt(input logic [31:0] c, input logic [7:0] ctl);
    return {2'b00, c[31:24], 1'b1, 2'b00, c[23:16], 1'b1, 2'b00, c[15:8], 1'b1,
            2'b00, c[7:0], 1'b1, 2'b01, ctl, 1'b1};
  endfunction

  // {sout, busy, done, overrun}
  function automatic logic [3:0] outs(input int which);
    return (which != 0) ? {sout_b, busy_b, done_b, ovr_b} : {sout_a, busy_a, done_a, ovr_a};
  endfunction

  task automatic drive(input int which, input logic r, input logic d, input logic [54:0] a);
    if (which != 0) begin
      rst_b = r; dr_b = d; alu_b = a;
    end else begin
      rst_a = r; dr_a = d; alu_a = a;
    end
  endtask

  // Reference waveform: list of words, each sent MSB-first, every bit held
  // cpb cycles, gap*cpb idle-high cycles between words (none after the last).
  task automatic build_exp(input logic [54:0] pkt, input int which);
    logic [10:0] words[$];
    int cpb, gap;
    cpb = cpb_of(which);
    gap = gap_of(which);
    exp_q.delete();
    if (pkt[8]) words.push_back(pkt[10:0]);      // CTL data bit 7: error packet
    else for (int n = 0; n < 5; n++) words.push_back(pkt[54-11*n -: 11]);
    for (int n = 0; n < words.size(); n++) begin
      if (n > 0) repeat (gap * cpb) exp_q.push_back(1'b1);
      for (int b = 10; b >= 0; b--) repeat (cpb) exp_q.push_back(words[n][b]);
    end
  endtask

  // Offer a packet for one cycle; returns at the falling edge of cycle k+1.
  task automatic start_pkt(input int which, input logic [54:0] pkt);
    @(negedge clk);
    drive(which, 1'b0, 1'b1, pkt);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, rnd55());
  endtask

  task automatic reset_dut(input int which);
    @(negedge clk);
    drive(which, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    logic [3:0] o;
    for (int w = 0; w < 2; w++) begin
      drive(w, 1'b1, 1'b0, rnd55());
      repeat (2) @(negedge clk);
      o = outs(w);
      vectors++;
      if (o !== 4'b1000) begin
        miscompares++;
        $display("FAIL reset dut%0d: sout/busy/done/ovr=%b required 1000", w, o);
      end
      drive(w, 1'b0, 1'b0, '0);
      $display("reset: dut%0d outs=%b", w, o);
    end
  endtask

  // One packet, checked bit-for-bit, then the done cycle and a following idle cycle.
  task automatic test_packet(input int which, input logic [54:0] pkt, input string label);
    logic [3:0] o;
    logic       ovr0;
    int         n;
    build_exp(pkt, which);
    n = exp_q.size();
    start_pkt(which, pkt);
    ovr0 = outs(which) & 4'b0001 ? 1'b1 : 1'b0;
    for (int i = 0; i < n; i++) begin
      o = outs(which);
      vectors++;
      if (o[3:1] !== {exp_q[i], 2'b10} || o[0] !== ovr0) begin
        miscompares++;
        $display("FAIL %s dut%0d cycle %0d: outs=%b required %b10%b", label, which, i, o, exp_q[i], ovr0);
      end
      @(negedge clk);
    end
    o = outs(which);
    vectors++;
    if (o[3:1] !== 3'b101) begin
      miscompares++;
      $display("FAIL %s dut%0d done cycle: sout/busy/done=%b required 101", label, which, o[3:1]);
    end
    @(negedge clk);
    o = outs(which);
    vectors++;
    if (o[3:1] !== 3'b100) begin
      miscompares++;
      $display("FAIL %s dut%0d after done: sout/busy/done=%b required 100", label, which, o[3:1]);
    end
    $display("%s: dut%0d pkt=%h cycles=%0d", label, which, pkt, n);
  endtask

  task automatic test_normal();
    test_packet(0, make_pkt(32'h12345678, 8'h07), "normal");
    for (int t = 0; t < 3; t++) begin
      test_packet(0, make_pkt($urandom, 8'($urandom) & 8'h7F), "normal_rnd");
      test_packet(1, make_pkt($urandom, 8'($urandom) & 8'h7F), "normal_rnd");
    end
  endtask

  task automatic test_error();
    logic [54:0] p;
    p = rnd55();
    p[10:0] = {2'b01, 8'hC9, 1'b1};
    test_packet(0, p, "error");
    test_packet(1, p, "error");
    for (int t = 0; t < 2; t++) begin
      p = rnd55();
      p[10:0] = {2'b01, 8'($urandom) | 8'h80, 1'b1};
      test_packet(t, p, "error_rnd");
    end
  endtask

  task automatic test_gap_rate();
    test_packet(1, make_pkt(32'hFFFFFFFF, 8'h00), "gap_rate");
  endtask

  // Second data_ready at cycle k+20 (index 19) during the first packet.
  task automatic test_overrun(input int which, input int drop_idx, input string label);
    logic [3:0]  o;
    logic [54:0] pkt;
    int          n;
    pkt = make_pkt($urandom, 8'($urandom) & 8'h7F);
    build_exp(pkt, which);
    n = exp_q.size();
    start_pkt(which, pkt);
    for (int i = 0; i < n; i++) begin
      o = outs(which);
      vectors++;
      if (o !== {exp_q[i], 2'b10, (i > drop_idx) ? 1'b1 : 1'b0}) begin
        miscompares++;
        $display("FAIL %s cycle %0d: outs=%b required %b10%b", label, i, o, exp_q[i], i > drop_idx);
      end
      if (i == drop_idx) drive(which, 1'b0, 1'b1, rnd55());
      else drive(which, 1'b0, 1'b0, rnd55());
      @(negedge clk);
    end
    drive(which, 1'b0, 1'b0, rnd55());
    o = outs(which);
    vectors++;
    if (o !== 4'b1011) begin
      miscompares++;
      $display("FAIL %s done cycle: outs=%b required 1011", label, o);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      o = outs(which);
      vectors++;
      if (o !== 4'b1001) begin
        miscompares++;
        $display("FAIL %s idle %0d: outs=%b required 1001", label, i, o);
      end
    end
    $display("%s: dut%0d pkt=%h drop at index %0d", label, which, pkt, drop_idx);
  endtask

  // Second packet offered in the done cycle must start on the next cycle.
  task automatic test_back_to_back(input int which);
    logic [3:0]  o;
    logic [54:0] p1, p2;
    int          n;
    reset_dut(which);
    p1 = make_pkt($urandom, 8'($urandom) & 8'h7F);
    p2 = make_pkt($urandom, 8'($urandom));
    build_exp(p1, which);
    n = exp_q.size();
    start_pkt(which, p1);
    for (int i = 0; i < n; i++) begin
      o = outs(which);
      vectors++;
      if (o !== {exp_q[i], 3'b100}) begin
        miscompares++;
        $display("FAIL b2b first dut%0d cycle %0d: outs=%b required %b100", which, i, o, exp_q[i]);
      end
      @(negedge clk);
    end
    o = outs(which);
    vectors++;
    if (o !== 4'b1010) begin
      miscompares++;
      $display("FAIL b2b done dut%0d: outs=%b required 1010", which, o);
    end
    drive(which, 1'b0, 1'b1, p2);
    build_exp(p2, which);
    n = exp_q.size();
    @(negedge clk);
    drive(which, 1'b0, 1'b0, rnd55());
    for (int i = 0; i < n; i++) begin
      o = outs(which);
      vectors++;
      if (o !== {exp_q[i], 3'b100}) begin
        miscompares++;
        $display("FAIL b2b second dut%0d cycle %0d: outs=%b required %b100", which, i, o, exp_q[i]);
      end
      @(negedge clk);
    end
    o = outs(which);
    vectors++;
    if (o !== 4'b1010) begin
      miscompares++;
      $display("FAIL b2b second done dut%0d: outs=%b required 1010", which, o);
    end
    $display("back_to_back: dut%0d p1=%h p2=%h", which, p1, p2);
  endtask

  // Reset sampled at the end of cycle k+30; the packet is abandoned silently.
  task automatic test_reset_mid();
    logic [3:0]  o;
    logic [54:0] pkt;
    int          bad;
    pkt = make_pkt($urandom, 8'($urandom) & 8'h7F);
    build_exp(pkt, 0);
    start_pkt(0, pkt);
    for (int i = 0; i < 30; i++) begin
      o = outs(0);
      vectors++;
      if (o[3:1] !== {exp_q[i], 2'b10}) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: sout/busy/done=%b required %b10", i, o[3:1], exp_q[i]);
      end
      if (i == 29) drive(0, 1'b1, 1'b0, rnd55());
      @(negedge clk);
    end
    o = outs(0);
    vectors++;
    if (o !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_mid k+31: outs=%b required 1000", o);
    end
    drive(0, 1'b0, 1'b0, rnd55());
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (outs(0) !== 4'b1000) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_mid quiet: %0d non-idle cycles required 0", bad);
    end
    $display("reset_mid: pkt=%h abandoned", pkt);
    test_packet(0, make_pkt($urandom, 8'($urandom) & 8'h7F), "after_reset");
  endtask

  initial begin
    drive(0, 1'b1, 1'b0, '0);
    drive(1, 1'b1, 1'b0, '0);
    test_reset();
    test_normal();
    test_error();
    test_gap_rate();
    test_overrun(0, 19, "overrun");
    test_overrun(1, 251, "overrun_last");
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
